// File: rtl/bht_sweep_predictor.sv
// bht_sweep_predictor: per-slot branch history table with a non-reset array
// that a row-sweep FSM invalidates after reset and after every flush.
module bht_sweep_predictor #(
  parameter int VLEN            = 32,
  parameter int NR_ENTRIES      = 1024,
  parameter int INSTR_PER_FETCH = 2,
  parameter int CTR_WIDTH       = 2,
  parameter int RVC             = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  output logic                       ready_o,
  output logic [INSTR_PER_FETCH-1:0] bht_valid_o,
  output logic [INSTR_PER_FETCH-1:0] bht_taken_o
);
  localparam int OFFSET   = (RVC != 0) ? 1 : 2;
  localparam int NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int COL_BITS = $clog2(INSTR_PER_FETCH);
  localparam int ROW_BITS = $clog2(NR_ROWS);
  localparam int CW       = (COL_BITS > 0) ? COL_BITS : 1;
  localparam logic [ROW_BITS-1:0]  LAST_ROW = ROW_BITS'(NR_ROWS - 1);
  localparam logic [CTR_WIDTH-1:0] WEAK_T   = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] WEAK_N   = WEAK_T - CTR_WIDTH'(1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

  typedef enum logic {INIT, READY} state_t;

  state_t                     state_q, state_d;
  logic [ROW_BITS-1:0]        row_q, row_d;
  logic [INSTR_PER_FETCH-1:0] valid_q [NR_ROWS];
  logic [CTR_WIDTH-1:0]       ctr_q   [NR_ROWS][INSTR_PER_FETCH];
  logic [ROW_BITS-1:0]        vpc_row, upd_row;
  logic [CW-1:0]              upd_col;
  logic                       upd_en, vld_old;
  logic [CTR_WIDTH-1:0]       ctr_old, ctr_new;
  logic                       unused_pc_bits;

  assign unused_pc_bits = ^{vpc_i, upd_pc_i};
  assign vpc_row = vpc_i[OFFSET+COL_BITS +: ROW_BITS];
  assign upd_row = upd_pc_i[OFFSET+COL_BITS +: ROW_BITS];
  assign upd_col = (INSTR_PER_FETCH == 1) ? '0 : upd_pc_i[OFFSET +: CW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // A flush always wins, restarting the sweep from row 0 in either state.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (state_q == INIT) begin
      row_d   = row_q + ROW_BITS'(1);
      state_d = (row_q == LAST_ROW) ? READY : INIT;
    end
    if (flush_bp_i) begin
      state_d = INIT;
      row_d   = '0;
    end
  end

  assign ready_o = (state_q == READY);
  assign upd_en  = upd_valid_i & ready_o & ~flush_bp_i & ~debug_mode_i;
  assign vld_old = valid_q[upd_row][upd_col];
  assign ctr_old = ctr_q[upd_row][upd_col];

  always_comb begin
    ctr_new = !vld_old    ? (upd_taken_i ? WEAK_T : WEAK_N) :
              upd_taken_i ? ((ctr_old == CTR_MAX) ? ctr_old : ctr_old + CTR_WIDTH'(1)) :
                            ((ctr_old == '0) ? ctr_old : ctr_old - CTR_WIDTH'(1));
  end

  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      valid_q[row_q] <= '0;
    end else if (upd_en) begin
      valid_q[upd_row][upd_col] <= 1'b1;
      ctr_q[upd_row][upd_col]   <= ctr_new;
    end
  end

  for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_slot
    assign bht_valid_o[i] = ready_o & valid_q[vpc_row][i];
    assign bht_taken_o[i] = bht_valid_o[i] & ctr_q[vpc_row][i][CTR_WIDTH-1];
  end
endmodule

// File: tb/tb_bht_sweep_predictor.sv
// tb_bht_sweep_predictor: directed bench for bht_sweep_predictor with a
// lookup scoreboard and cycle-accurate init/flush latency checks.
module tb_bht_sweep_predictor;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_bp_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [31:0] vpc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        ready_o;
  logic [1:0]  bht_valid_o;
  logic [1:0]  bht_taken_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string    tag;
    logic [1:0] valid;
    logic [1:0] taken;
  } exp_t;
  exp_t sb[$];

  bht_sweep_predictor dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i),
    .debug_mode_i(debug_mode_i), .vpc_i(vpc_i), .upd_valid_i(upd_valid_i),
    .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i), .ready_o(ready_o),
    .bht_valid_o(bht_valid_o), .bht_taken_o(bht_taken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic [1:0] v, input logic [1:0] t);
    exp_t e;
    vpc_i = pc;
    sb.push_back('{tag, v, t});
    @(negedge clk_i);
    e = sb.pop_front();
    check({e.tag, "_valid"}, 32'(bht_valid_o), 32'(e.valid));
    check({e.tag, "_taken"}, 32'(bht_taken_o), 32'(e.taken));
  endtask

  task automatic update(input logic [31:0] pc, input logic taken);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = taken;
    tick();
    upd_valid_i = 1'b0;
  endtask

  task automatic flush();
    flush_bp_i = 1'b1;
    tick();
    flush_bp_i = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int expected);
    int n = 0;
    while (!ready_o && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(expected));
  endtask

  initial begin
    repeat (3) tick();
    check("reset_ready", 32'(ready_o), 32'd0);
    lookup("reset_out", 32'h8000_0000, 2'b00, 2'b00);
    rst_ni = 1'b1;
    wait_ready("init_latency", 512);
    lookup("after_init", 32'h8000_0000, 2'b00, 2'b00);

    update(32'h8000_0002, 1'b1);
    lookup("first_upd", 32'h8000_0000, 2'b10, 2'b10);
    check("first_ctr", 32'(dut.ctr_q[0][1]), 32'h2);

    repeat (3) update(32'h8000_0002, 1'b1);
    check("sat_hi_ctr", 32'(dut.ctr_q[0][1]), 32'h3);
    update(32'h8000_0002, 1'b0);
    lookup("hyst_taken", 32'h8000_0000, 2'b10, 2'b10);
    check("hyst_ctr", 32'(dut.ctr_q[0][1]), 32'h2);
    update(32'h8000_0002, 1'b0);
    lookup("weak_nt", 32'h8000_0000, 2'b10, 2'b00);
    update(32'h8000_0002, 1'b0);
    check("low_ctr", 32'(dut.ctr_q[0][1]), 32'h0);
    update(32'h8000_0002, 1'b0);
    check("sat_lo_ctr", 32'(dut.ctr_q[0][1]), 32'h0);

    // Update in flight: lookup that same cycle must still see the old value.
    upd_valid_i = 1'b1; upd_pc_i = 32'h8000_0002; upd_taken_i = 1'b1;
    lookup("same_cycle_old", 32'h8000_0000, 2'b10, 2'b00);
    tick();
    upd_valid_i = 1'b0;
    lookup("next_cycle_new", 32'h8000_0000, 2'b10, 2'b00);
    update(32'h8000_0002, 1'b1);
    lookup("b2b_upd", 32'h8000_0000, 2'b10, 2'b10);

    update(32'h8000_0000, 1'b1);
    lookup("alias", 32'h8000_0800, 2'b11, 2'b11);
    update(32'h8000_0000, 1'b0);
    lookup("weak_t_dec", 32'h8000_0000, 2'b11, 2'b10);

    debug_mode_i = 1'b1;
    update(32'h8000_0100, 1'b1);
    debug_mode_i = 1'b0;
    lookup("debug_drop", 32'h8000_0100, 2'b00, 2'b00);

    flush();
    check("flush_ready_drop", 32'(ready_o), 32'd0);
    lookup("init_gated", 32'h8000_0000, 2'b00, 2'b00);
    tick();
    update(32'h8000_0000, 1'b1);
    wait_ready("flush_latency", 510);
    lookup("init_drop", 32'h8000_0000, 2'b00, 2'b00);

    update(32'h8000_0000, 1'b1);
    lookup("repop", 32'h8000_0000, 2'b01, 2'b01);
    flush();
    repeat (100) tick();
    check("sweep_row_100", 32'(dut.row_q), 32'd100);
    flush();
    wait_ready("reflush_latency", 512);
    lookup("reflush_clear", 32'h8000_0000, 2'b00, 2'b00);

    flush_bp_i = 1'b1;
    update(32'h8000_0004, 1'b1);
    flush_bp_i = 1'b0;
    check("flush_upd_ready", 32'(ready_o), 32'd0);
    wait_ready("flush_upd_latency", 512);
    lookup("flush_upd_drop", 32'h8000_0004, 2'b00, 2'b00);

    flush();
    repeat (50) tick();
    #2 rst_ni = 1'b0;
    #1 check("midsweep_rst_row", 32'(dut.row_q), 32'd0);
    tick();
    rst_ni = 1'b1;
    wait_ready("rst_latency", 512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
